msrv32_dmem_if: RTL and testbench
=================================

# msrv32_dmem_if

Data-memory bus interface for the msrv32 core. Accepts one load/store request at a time from the execute stage and runs it as a single AHB-Lite transfer with byte strobes. Registers the returned read data, together with the request's size, signedness and low address bits, for the load unit directly downstream. Stalls the pipeline while a transfer is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: consecutive `hready_in`-low cycles before abort. Only used with the timeout feature; valid range 1..65535.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `req_in` in 1: request. Sampled only in IDLE.
- `we_in` in 1: 1 = store, 0 = load.
- `addr_in` in 32: byte address.
- `wdata_in` in 32: store data, right-justified.
- `load_size_in` in 2: 00 byte, 01 half, 10/11 word.
- `load_unsigned_in` in 1: zero-extend a load.
- `stall_out` out 1: pipeline freeze.
- `done_out` out 1: one-cycle completion pulse.
- `misaligned_out` out 1: one-cycle pulse; request rejected.
- `bus_err_out` out 1: one-cycle pulse; transfer failed.
- `haddr_out` out 32, `htrans_out` out 2, `hwrite_out` out 1, `hsize_out` out 3: AHB address phase.
- `hwdata_out` out 32, `hwstrb_out` out 4: AHB write data phase.
- `hready_in` in 1, `hresp_in` in 1, `hrdata_in` in 32: AHB response.
- `lu_data_out` out 32: captured `hrdata_in`, to the load unit.
- `lu_size_out` out 2, `lu_unsigned_out` out 1, `lu_addr_1_0_out` out 2: request attributes, held with the data.
- `ahb_resp_out` out 1: 0 = `lu_data_out` valid.

## Operation
- States: IDLE, ADDR, DATA, DONE, ERR.
- Accept:
  - `req_in`=1 in IDLE latches all request inputs.
  - Misaligned requests go IDLE→ERR-free path: `misaligned_out` pulses next cycle, state stays IDLE, no bus transfer.
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Aligned requests go to ADDR.
- ADDR: `htrans_out`=NONSEQ (2'b10), plus registered `haddr_out`, `hwrite_out` and `hsize_out` (0/1/2). With `hready_in`=1 → DATA; otherwise hold ADDR.
- DATA:
  - `htrans_out`=IDLE.
  - For stores, `hwdata_out`/`hwstrb_out` are driven:
    - byte: data replicated ×4, strobe 4'b0001<<addr[1:0];
    - half: data replicated ×2, strobe 4'b0011<<{addr[1],0};
    - word: data as is, strobe 4'b1111.
  - `hready_in`=1 and `hresp_in`=0 → DONE; for loads, capture `hrdata_in` into `lu_data_out`.
  - `hresp_in`=1 → ERR.
- DONE: `done_out`=1 → IDLE.
- ERR: `bus_err_out`=1 → IDLE.
- `ahb_resp_out`:
  - 0 from DONE of a load until the next accepted request.
  - 1 after reset, while busy, after a store, after a misalign, and after an error.
- `stall_out` = (IDLE & `req_in` & aligned) | ADDR | DATA. It is combinational, so the pipeline freezes in the accept cycle.
- `lu_*` attribute outputs update at accept and hold until the next accept.

## Timing
- Reset values:
  - state IDLE;
  - `htrans_out`=2'b00;
  - all data, address and strobe outputs 0;
  - all pulse outputs 0;
  - `ahb_resp_out`=1.
- Minimum latency with zero wait states: request in cycle N, ADDR at N+1, DATA at N+2, `done_out` and valid `lu_data_out` at N+3.
- Each `hready_in`-low cycle in ADDR or DATA adds one cycle.
- The cycle after DONE/ERR is IDLE and can accept a new request; there is no back-to-back pipelining.
- `req_in` during a transfer is ignored. The pipeline must hold it while `stall_out`=1.
- Reset mid-transfer: everything returns to reset values at the next edge and the transfer is abandoned; `htrans_out`=IDLE.

## Configuration
- `MSRV32_DMEM_TIMEOUT_EN` defined:
  - a 16-bit counter counts consecutive `hready_in`=0 cycles in ADDR/DATA and clears when `hready_in`=1 or the state changes;
  - reaching `TIMEOUT_CYCLES` → ERR, with `htrans_out` forced IDLE.
- Undefined: no counter; the block waits indefinitely; `bus_err_out` is raised only by `hresp_in`.

## Structure
- Package `msrv32_dmem_pkg`:
  - state enum;
  - HTRANS codes (IDLE, NONSEQ);
  - HSIZE codes;
  - load size encodings.
- Sub-module `msrv32_dmem_align` (combinational): size/address → strobe, replicated write data, misalign flag.

## Test plan
- Word load at 0x100, zero wait, `hrdata_in`=0xDEADBEEF → `done_out` at N+3, `lu_data_out`=0xDEADBEEF, `ahb_resp_out`=0.
- Byte store 0xA5 at 0x203 → `hwstrb_out`=4'b1000, `hwdata_out`=0xA5A5A5A5, `hsize_out`=0, `ahb_resp_out` stays 1.
- Half load at 0x101 → `misaligned_out` pulse, `htrans_out` never NONSEQ, `stall_out` never high.
- Word load with `hready_in` low 3 cycles in DATA → `done_out` at N+6, `stall_out` high N..N+5.
- `hresp_in`=1 in DATA → `bus_err_out` pulse, `ahb_resp_out`=1, next request accepted.
- With `MSRV32_DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `hready_in` stuck 0 → ERR after 4 stalled cycles. Separately, `rst_in` asserted in DATA → next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/msrv32_dmem_pkg.sv
// Shared types and bus encodings for the msrv32 data-memory interface.
package msrv32_dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Map the core's load/store size encoding onto AHB HSIZE.
  function automatic logic [2:0] size_to_hsize(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_hsize = HSIZE_BYTE;
      SIZE_HALF: size_to_hsize = HSIZE_HALF;
      default:   size_to_hsize = HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_dmem_if_if.sv
// AHB-Lite signal bundle between the data-memory interface (master) and memory (slave).
interface msrv32_dmem_if_if;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [3:0]  hwstrb_out;
  logic        hready_in;
  logic        hresp_in;
  logic [31:0] hrdata_in;

  modport master (
    output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwstrb_out,
    input  hready_in, hresp_in, hrdata_in
  );

  modport slave (
    input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out, hwstrb_out,
    output hready_in, hresp_in, hrdata_in
  );
endinterface

// File: rtl/msrv32_dmem_align.sv
// Size/address decode: byte strobes, lane-replicated store data, misalignment flag.
module msrv32_dmem_align
  import msrv32_dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  // Strobe and replication per access size.
  always_comb begin
    strb       = '1;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        strb      = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        strb       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_if.sv
// msrv32 data-memory bus interface: one load/store at a time as a single AHB-Lite transfer.
// Optional build macro MSRV32_DMEM_TIMEOUT_EN aborts a transfer after TIMEOUT_CYCLES
// consecutive hready_in-low cycles.
module msrv32_dmem_if
  import msrv32_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    req_in,
  input  logic                    we_in,
  input  logic [31:0]             addr_in,
  input  logic [31:0]             wdata_in,
  input  logic [1:0]              load_size_in,
  input  logic                    load_unsigned_in,
  output logic                    stall_out,
  output logic                    done_out,
  output logic                    misaligned_out,
  output logic                    bus_err_out,
  msrv32_dmem_if_if.master        ahb,
  output logic [31:0]             lu_data_out,
  output logic [1:0]              lu_size_out,
  output logic                    lu_unsigned_out,
  output logic [1:0]              lu_addr_1_0_out,
  output logic                    ahb_resp_out
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      state, state_next;
  logic [31:0] haddr_q, wdata_q;
  logic [3:0]  strb_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;
  logic [3:0]  strb_c;
  logic [31:0] wdata_rep_c;
  logic        misaligned_c;
  logic        accept;
  logic        timeout_hit;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;

  msrv32_dmem_align u_align (
    .size       (load_size_in),
    .addr_lo    (addr_in[1:0]),
    .wdata      (wdata_in),
    .strb       (strb_c),
    .wdata_rep  (wdata_rep_c),
    .misaligned (misaligned_c)
  );

  assign accept = (state == ST_IDLE) && req_in;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  assign timeout_hit = !ahb.hready_in && (tmo_cnt == TMO_LAST);

  // Consecutive wait-state counter; restarts on any ready or state change.
  always_ff @(posedge clk_in) begin
    if (rst_in || ahb.hready_in || (state_next != state) ||
        !((state == ST_ADDR) || (state == ST_DATA)))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and combinational bus/handshake outputs.
  always_comb begin
    state_next  = state;
    htrans      = HTRANS_IDLE;
    hwdata      = '0;
    hwstrb      = '0;
    stall_out   = 1'b0;
    done_out    = 1'b0;
    bus_err_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_in && !misaligned_c) begin
          state_next = ST_ADDR;
          stall_out  = 1'b1;
        end
      end
      ST_ADDR: begin
        htrans    = HTRANS_NONSEQ;
        stall_out = 1'b1;
        if (ahb.hready_in)    state_next = ST_DATA;
        else if (timeout_hit) state_next = ST_ERR;
      end
      ST_DATA: begin
        stall_out = 1'b1;
        if (hwrite_q) begin
          hwdata = wdata_q;
          hwstrb = strb_q;
        end
        if (ahb.hresp_in)       state_next = ST_ERR;
        else if (ahb.hready_in) state_next = ST_DONE;
        else if (timeout_hit)   state_next = ST_ERR;
      end
      ST_DONE: begin
        done_out   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        bus_err_out = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, misalign pulse, load-data capture and response flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      haddr_q         <= '0;
      wdata_q         <= '0;
      strb_q          <= '0;
      hsize_q         <= '0;
      hwrite_q        <= 1'b0;
      misaligned_out  <= 1'b0;
      lu_data_out     <= '0;
      lu_size_out     <= '0;
      lu_unsigned_out <= 1'b0;
      lu_addr_1_0_out <= '0;
      ahb_resp_out    <= 1'b1;
    end else begin
      misaligned_out <= 1'b0;
      if (accept) begin
        lu_size_out     <= load_size_in;
        lu_unsigned_out <= load_unsigned_in;
        lu_addr_1_0_out <= addr_in[1:0];
        ahb_resp_out    <= 1'b1;
        if (misaligned_c) begin
          misaligned_out <= 1'b1;
        end else begin
          haddr_q  <= addr_in;
          hwrite_q <= we_in;
          hsize_q  <= size_to_hsize(load_size_in);
          wdata_q  <= wdata_rep_c;
          strb_q   <= strb_c;
        end
      end
      if ((state == ST_DATA) && ahb.hready_in && !ahb.hresp_in && !hwrite_q) begin
        lu_data_out  <= ahb.hrdata_in;
        ahb_resp_out <= 1'b0;
      end
    end
  end

  assign ahb.haddr_out  = haddr_q;
  assign ahb.htrans_out = htrans;
  assign ahb.hwrite_out = hwrite_q;
  assign ahb.hsize_out  = hsize_q;
  assign ahb.hwdata_out = hwdata;
  assign ahb.hwstrb_out = hwstrb;

endmodule

// File: tb/tb_msrv32_dmem_if.sv
// Directed self-checking bench for msrv32_dmem_if.
// The timeout scenario is compiled in only when MSRV32_DMEM_TIMEOUT_EN is defined.
module tb_msrv32_dmem_if;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_in, we_in, load_unsigned_in;
  logic [31:0] addr_in, wdata_in;
  logic [1:0]  load_size_in;
  logic        stall_out, done_out, misaligned_out, bus_err_out;
  logic [31:0] lu_data_out;
  logic [1:0]  lu_size_out, lu_addr_1_0_out;
  logic        lu_unsigned_out, ahb_resp_out;

  int checks = 0;
  int failures = 0;

  msrv32_dmem_if_if bus ();

  msrv32_dmem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_in           (req_in),
    .we_in            (we_in),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .stall_out        (stall_out),
    .done_out         (done_out),
    .misaligned_out   (misaligned_out),
    .bus_err_out      (bus_err_out),
    .ahb              (bus.master),
    .lu_data_out      (lu_data_out),
    .lu_size_out      (lu_size_out),
    .lu_unsigned_out  (lu_unsigned_out),
    .lu_addr_1_0_out  (lu_addr_1_0_out),
    .ahb_resp_out     (ahb_resp_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; req_in = 1'b0; we_in = 1'b0; load_unsigned_in = 1'b0;
    addr_in = '0; wdata_in = '0; load_size_in = 2'b00;
    bus.hready_in = 1'b1; bus.hresp_in = 1'b0; bus.hrdata_in = '0;
    tick; tick;
    rst_in = 1'b0;

    // Reset state
    chk("rst_htrans", 32'(bus.htrans_out), 0);
    chk("rst_haddr", bus.haddr_out, 0);
    chk("rst_hwstrb", 32'(bus.hwstrb_out), 0);
    chk("rst_hwdata", bus.hwdata_out, 0);
    chk("rst_done", 32'(done_out), 0);
    chk("rst_mis", 32'(misaligned_out), 0);
    chk("rst_berr", 32'(bus_err_out), 0);
    chk("rst_resp", 32'(ahb_resp_out), 1);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_lu_data", lu_data_out, 0);

    // Word load at 0x100, zero wait
    req_in = 1'b1; we_in = 1'b0; addr_in = 32'h100; load_size_in = 2'b10;
    bus.hrdata_in = 32'hDEADBEEF;
    #1 chk("ld_stall_n", 32'(stall_out), 1);
    tick; req_in = 1'b0;
    chk("ld_htrans_a", 32'(bus.htrans_out), 2);
    chk("ld_haddr", bus.haddr_out, 32'h100);
    chk("ld_hsize", 32'(bus.hsize_out), 2);
    chk("ld_hwrite", 32'(bus.hwrite_out), 0);
    chk("ld_stall_a", 32'(stall_out), 1);
    chk("ld_done_a", 32'(done_out), 0);
    tick;
    chk("ld_htrans_d", 32'(bus.htrans_out), 0);
    chk("ld_stall_d", 32'(stall_out), 1);
    chk("ld_done_d", 32'(done_out), 0);
    tick;
    chk("ld_done", 32'(done_out), 1);
    chk("ld_lu_data", lu_data_out, 32'hDEADBEEF);
    chk("ld_resp", 32'(ahb_resp_out), 0);
    chk("ld_stall_done", 32'(stall_out), 0);
    chk("ld_lu_size", 32'(lu_size_out), 2);
    tick;
    chk("ld_done_after", 32'(done_out), 0);
    chk("ld_resp_hold", 32'(ahb_resp_out), 0);

    // Half load at 0x101: misaligned, no transfer
    req_in = 1'b1; load_size_in = 2'b01; addr_in = 32'h101;
    #1 chk("mh_stall_n", 32'(stall_out), 0);
    tick; req_in = 1'b0;
    chk("mh_pulse", 32'(misaligned_out), 1);
    chk("mh_htrans", 32'(bus.htrans_out), 0);
    chk("mh_stall", 32'(stall_out), 0);
    chk("mh_resp", 32'(ahb_resp_out), 1);
    chk("mh_lu_addr", 32'(lu_addr_1_0_out), 1);
    chk("mh_lu_size", 32'(lu_size_out), 1);
    tick;
    chk("mh_pulse_end", 32'(misaligned_out), 0);
    chk("mh_htrans2", 32'(bus.htrans_out), 0);

    // Word load at 0x102: misaligned
    req_in = 1'b1; load_size_in = 2'b10; addr_in = 32'h102;
    #1 chk("mw_stall_n", 32'(stall_out), 0);
    tick; req_in = 1'b0;
    chk("mw_pulse", 32'(misaligned_out), 1);
    chk("mw_htrans", 32'(bus.htrans_out), 0);
    tick;

    // Byte store 0xA5 at 0x203
    req_in = 1'b1; we_in = 1'b1; load_size_in = 2'b00; addr_in = 32'h203;
    wdata_in = 32'hFFFFFFA5;
    #1 chk("sb_stall_n", 32'(stall_out), 1);
    tick; req_in = 1'b0;
    chk("sb_htrans", 32'(bus.htrans_out), 2);
    chk("sb_hsize", 32'(bus.hsize_out), 0);
    chk("sb_hwrite", 32'(bus.hwrite_out), 1);
    chk("sb_haddr", bus.haddr_out, 32'h203);
    chk("sb_strb_a", 32'(bus.hwstrb_out), 0);
    tick;
    chk("sb_strb", 32'(bus.hwstrb_out), 32'h8);
    chk("sb_wdata", bus.hwdata_out, 32'hA5A5A5A5);
    chk("sb_htrans_d", 32'(bus.htrans_out), 0);
    tick;
    chk("sb_done", 32'(done_out), 1);
    chk("sb_resp", 32'(ahb_resp_out), 1);
    chk("sb_strb_done", 32'(bus.hwstrb_out), 0);
    tick;

    // Half store 0xBEEF at 0x102, one wait state in ADDR
    req_in = 1'b1; we_in = 1'b1; load_size_in = 2'b01; addr_in = 32'h102;
    wdata_in = 32'h1234BEEF; bus.hready_in = 1'b0;
    tick; req_in = 1'b0;
    chk("sh_htrans_a1", 32'(bus.htrans_out), 2);
    tick;
    chk("sh_htrans_a2", 32'(bus.htrans_out), 2);
    chk("sh_stall_a2", 32'(stall_out), 1);
    bus.hready_in = 1'b1;
    tick;
    chk("sh_strb", 32'(bus.hwstrb_out), 32'hC);
    chk("sh_wdata", bus.hwdata_out, 32'hBEEFBEEF);
    tick;
    chk("sh_done", 32'(done_out), 1);
    tick;

    // Word load at 0x200, hready low 3 cycles in DATA
    req_in = 1'b1; we_in = 1'b0; load_size_in = 2'b10; addr_in = 32'h200;
    bus.hrdata_in = 32'h0;
    #1 chk("wt_stall_n", 32'(stall_out), 1);
    tick; req_in = 1'b0;                       // N+1 ADDR
    chk("wt_stall_n1", 32'(stall_out), 1);
    tick;                                      // N+2 DATA
    chk("wt_stall_n2", 32'(stall_out), 1);
    chk("wt_done_n2", 32'(done_out), 0);
    bus.hready_in = 1'b0;
    tick;                                      // N+3
    chk("wt_stall_n3", 32'(stall_out), 1);
    chk("wt_htrans_n3", 32'(bus.htrans_out), 0);
    req_in = 1'b1; addr_in = 32'h444;          // must be ignored
    tick;                                      // N+4
    chk("wt_stall_n4", 32'(stall_out), 1);
    chk("wt_haddr_n4", bus.haddr_out, 32'h200);
    chk("wt_done_n4", 32'(done_out), 0);
    req_in = 1'b0;
    tick;                                      // N+5
    chk("wt_stall_n5", 32'(stall_out), 1);
    chk("wt_done_n5", 32'(done_out), 0);
    bus.hready_in = 1'b1; bus.hrdata_in = 32'h11223344;
    tick;                                      // N+6
    chk("wt_done_n6", 32'(done_out), 1);
    chk("wt_lu_data", lu_data_out, 32'h11223344);
    chk("wt_resp", 32'(ahb_resp_out), 0);
    chk("wt_stall_n6", 32'(stall_out), 0);
    tick;

    // Error response in DATA, then a fresh request is accepted
    req_in = 1'b1; addr_in = 32'h300; load_size_in = 2'b10;
    tick; req_in = 1'b0;
    tick;
    bus.hresp_in = 1'b1; bus.hready_in = 1'b0;
    tick;
    chk("er_berr", 32'(bus_err_out), 1);
    chk("er_done", 32'(done_out), 0);
    chk("er_resp", 32'(ahb_resp_out), 1);
    chk("er_lu_data", lu_data_out, 32'h11223344);
    bus.hresp_in = 1'b0; bus.hready_in = 1'b1;
    tick;
    chk("er_berr_end", 32'(bus_err_out), 0);
    req_in = 1'b1; load_size_in = 2'b00; addr_in = 32'h301; load_unsigned_in = 1'b1;
    bus.hrdata_in = 32'hAABBCCDD;
    #1 chk("er_next_stall", 32'(stall_out), 1);
    tick; req_in = 1'b0;
    chk("er_next_htrans", 32'(bus.htrans_out), 2);
    chk("er_next_haddr", bus.haddr_out, 32'h301);
    chk("er_next_hsize", 32'(bus.hsize_out), 0);
    tick;
    tick;
    chk("er_next_done", 32'(done_out), 1);
    chk("er_next_data", lu_data_out, 32'hAABBCCDD);
    chk("er_next_lu_addr", 32'(lu_addr_1_0_out), 1);
    chk("er_next_lu_uns", 32'(lu_unsigned_out), 1);
    chk("er_next_lu_size", 32'(lu_size_out), 0);
    chk("er_next_resp", 32'(ahb_resp_out), 0);
    tick;

    // Reset asserted during DATA
    req_in = 1'b1; we_in = 1'b0; load_size_in = 2'b10; addr_in = 32'h400;
    load_unsigned_in = 1'b0;
    tick; req_in = 1'b0;
    tick;
    bus.hready_in = 1'b0; rst_in = 1'b1;
    tick;
    chk("rd_htrans", 32'(bus.htrans_out), 0);
    chk("rd_haddr", bus.haddr_out, 0);
    chk("rd_hsize", 32'(bus.hsize_out), 0);
    chk("rd_hwrite", 32'(bus.hwrite_out), 0);
    chk("rd_stall", 32'(stall_out), 0);
    chk("rd_done", 32'(done_out), 0);
    chk("rd_berr", 32'(bus_err_out), 0);
    chk("rd_resp", 32'(ahb_resp_out), 1);
    chk("rd_lu_data", lu_data_out, 0);
    chk("rd_lu_size", 32'(lu_size_out), 0);
    rst_in = 1'b0; bus.hready_in = 1'b1;
    tick;
    chk("rd_htrans_after", 32'(bus.htrans_out), 0);
    chk("rd_stall_after", 32'(stall_out), 0);

`ifdef MSRV32_DMEM_TIMEOUT_EN
    // hready stuck low in ADDR: abort after 4 stalled cycles
    req_in = 1'b1; addr_in = 32'h500; load_size_in = 2'b10; bus.hready_in = 1'b0;
    tick; req_in = 1'b0;
    chk("to_htrans_1", 32'(bus.htrans_out), 2);
    tick;
    chk("to_htrans_2", 32'(bus.htrans_out), 2);
    tick;
    chk("to_htrans_3", 32'(bus.htrans_out), 2);
    tick;
    chk("to_htrans_4", 32'(bus.htrans_out), 2);
    chk("to_berr_4", 32'(bus_err_out), 0);
    tick;
    chk("to_berr", 32'(bus_err_out), 1);
    chk("to_htrans_err", 32'(bus.htrans_out), 0);
    chk("to_stall", 32'(stall_out), 0);
    bus.hready_in = 1'b1;
    tick;
    chk("to_berr_end", 32'(bus_err_out), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
